// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack data bus, stalls the pipeline until
// the access completes, formats load data and flags misaligned addresses.
module mem_stage #(
    parameter logic [7:0] OP_LB  = 8'hE0,
    parameter logic [7:0] OP_LBU = 8'hE4,
    parameter logic [7:0] OP_LH  = 8'hE1,
    parameter logic [7:0] OP_LHU = 8'hE5,
    parameter logic [7:0] OP_LW  = 8'hE3,
    parameter logic [7:0] OP_SB  = 8'hE8,
    parameter logic [7:0] OP_SH  = 8'hE9,
    parameter logic [7:0] OP_SW  = 8'hEB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] pc_i,
    input  logic        stall_hold,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] pc_o,
    output logic        stallreq,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] bad_vaddr
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    state_e      state_q;
    logic        dbus_req_q, dbus_we_q;
    logic [31:0] dbus_addr_q, dbus_wdata_q, rdata_q;
    logic [3:0]  dbus_sel_q;

    logic        is_load, is_store, is_mem, is_byte, is_half, is_signed, misaligned;
    logic [1:0]  offset;
    logic [3:0]  sel_d;
    logic [31:0] bus_wdata_d, load_data;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign offset = mem_addr_i[1:0];

    // NOTE: every signal assigned in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        case (aluop_i)
            OP_LB:   begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU:  begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH:   begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:   is_load  = 1'b1;
            OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:   is_store = 1'b1;
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (is_half & offset[0]) | (is_mem & ~is_byte & ~is_half & (offset != 2'b00));

    always_comb begin
        sel_d       = 4'b1111;
        bus_wdata_d = reg2_i;
        if (is_byte) begin
            sel_d       = 4'b1000 >> offset;
            bus_wdata_d = {4{reg2_i[7:0]}};
        end else if (is_half) begin
            sel_d       = offset[1] ? 4'b0011 : 4'b1100;
            bus_wdata_d = {2{reg2_i[15:0]}};
        end
    end

    // Big-endian lanes: byte offset 0 is the most significant byte of the word.
    always_comb begin
        case (offset)
            2'd0:    lane_b = rdata_q[31:24];
            2'd1:    lane_b = rdata_q[23:16];
            2'd2:    lane_b = rdata_q[15:8];
            default: lane_b = rdata_q[7:0];
        endcase
        lane_h = offset[1] ? rdata_q[15:0] : rdata_q[31:16];
        if (is_byte)
            load_data = {{24{is_signed & lane_b[7]}}, lane_b};
        else if (is_half)
            load_data = {{16{is_signed & lane_h[15]}}, lane_h};
        else
            load_data = rdata_q;
    end

    logic        stall_c, wreg_c, adel_c, ades_c;
    logic [31:0] wdata_c, bad_c;

    always_comb begin
        stall_c = 1'b0;
        wreg_c  = wreg_i;
        wdata_c = wdata_i;
        adel_c  = 1'b0;
        ades_c  = 1'b0;
        bad_c   = '0;
        case (state_q)
            IDLE: if (is_mem) begin
                wreg_c = 1'b0;
                if (misaligned) begin
                    adel_c = is_load;
                    ades_c = is_store;
                    bad_c  = mem_addr_i;
                end else begin
                    stall_c = 1'b1;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                wreg_c  = 1'b0;
            end
            DONE: begin
                if (is_store)
                    wreg_c = 1'b0;
                else if (is_load)
                    wdata_c = load_data;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_sel_q   <= '0;
            dbus_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (is_mem && !misaligned) begin
                    dbus_req_q   <= 1'b1;
                    dbus_we_q    <= is_store;
                    dbus_addr_q  <= {mem_addr_i[31:2], 2'b00};
                    dbus_sel_q   <= sel_d;
                    dbus_wdata_q <= bus_wdata_d;
                    state_q      <= REQ;
                end
                REQ: if (dbus_ack) begin
                    rdata_q    <= dbus_rdata;
                    dbus_req_q <= 1'b0;
                    dbus_we_q  <= 1'b0;
                    state_q    <= DONE;
                end
                DONE: if (!stall_hold) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_sel   = dbus_sel_q;
    assign dbus_wdata = dbus_wdata_q;

    // Combinational outputs are forced low while reset is held.
    assign stallreq  = rst & stall_c;
    assign wd_o      = rst ? wd_i : '0;
    assign wreg_o    = rst & wreg_c;
    assign wdata_o   = rst ? wdata_c : '0;
    assign pc_o      = rst ? pc_i : '0;
    assign exc_adel  = rst & adel_c;
    assign exc_ades  = rst & ades_c;
    assign bad_vaddr = rst ? bad_c : '0;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM pipeline register; feeds the MEM/WB register.
- Executes loads and stores over a req/ack data bus with variable latency, and holds the pipeline with stallreq until the access completes.
- Formats load data with byte/half extraction and sign or zero extension; generates the store byte-select and replicated write data.
- Flags misaligned accesses (AdEL/AdES) and suppresses the bus access for them.

Parameters:
- OP_LB, 8'hE0, aluop code for load byte signed
- OP_LBU, 8'hE4, load byte unsigned
- OP_LH, 8'hE1, load half signed
- OP_LHU, 8'hE5, load half unsigned
- OP_LW, 8'hE3, load word
- OP_SB, 8'hE8, store byte
- OP_SH, 8'hE9, store half
- OP_SW, 8'hEB, store word

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- wd_i  in  5  destination register address
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result
- aluop_i  in  8  operation code
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data
- pc_i  in  32  instruction PC
- stall_hold  in  1  downstream stall (MEM/WB frozen)
- dbus_rdata  in  32  read data, valid with dbus_ack
- dbus_ack  in  1  one-cycle completion pulse
- dbus_req  out  1  access request, registered
- dbus_we  out  1  write strobe, registered
- dbus_addr  out  32  word address {addr[31:2],2'b00}, registered
- dbus_sel  out  4  byte lanes, registered; bit3 = byte 0 (big-endian)
- dbus_wdata  out  32  write data, registered
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  write enable to MEM/WB
- wdata_o  out  32  writeback data
- pc_o  out  32  passthrough of pc_i
- stallreq  out  1  stall request to pipeline control
- exc_adel  out  1  load address error
- exc_ades  out  1  store address error
- bad_vaddr  out  32  faulting address, else 0

Behaviour:
- While rst=0: every output is 0, including combinational ones; FSM state is IDLE. Reset asserted during REQ drops dbus_req immediately, with no wait for ack.
- FSM states: IDLE, REQ, DONE.
- Memory op: aluop_i matches one of the 8 codes. Non-memory ops never leave IDLE. For them: stallreq=0, wd_o/wreg_o/wdata_o/pc_o = the inputs, zero latency.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Outputs: exc_adel (loads) or exc_ades (stores) =1, bad_vaddr=mem_addr_i, wreg_o=0.
  - No bus request, stallreq=0, FSM stays IDLE.
- IDLE, aligned memory op:
  - stallreq=1 combinationally.
  - Next edge: register dbus_req=1, dbus_we (1 for stores), dbus_addr, dbus_sel, dbus_wdata; go to REQ.
- dbus_sel:
  - Byte ops: offset 0..3 → 1000, 0100, 0010, 0001.
  - Half ops: offset 0 → 1100, offset 2 → 0011.
  - Word ops: 1111.
- dbus_wdata:
  - SB: {4{reg2_i[7:0]}}.
  - SH: {2{reg2_i[15:0]}}.
  - SW: reg2_i.
- REQ:
  - stallreq=1; bus outputs held stable.
  - On the edge where dbus_ack=1: capture dbus_rdata into rdata_q, clear dbus_req/dbus_we, go to DONE.
  - ack in the same cycle req first rises is legal; single-cycle latency minimum is REQ for 1 cycle.
- DONE:
  - stallreq=0, so the upstream register advances next edge.
  - Loads: wdata_o is formatted from rdata_q, wreg_o=wreg_i.
    - LB/LBU: the selected lane, sign/zero extended.
    - LH/LHU: the selected half, sign/zero extended.
    - LW: rdata_q.
  - Stores: wreg_o=0.
  - Leaves DONE for IDLE when stall_hold=0. While stall_hold=1, stays in DONE; the access is not reissued.
- dbus_ack in IDLE or DONE is ignored.
- Exceptions are combinational on inputs in IDLE only. They are never asserted in REQ/DONE.

Test Plan:
- LW, addr 0x100, ack 3 cycles after req → req high 3 cycles, sel=1111, stallreq high 4 cycles; in DONE wdata_o = rdata (0xDEADBEEF), stallreq drops.
- LB at 0x103, rdata 0x112233F0 → sel=0001, wdata_o=0xFFFFFFF0; LBU at the same address → 0x000000F0.
- SH at 0x202, reg2_i=0x0000ABCD → dbus_we=1, sel=0011, wdata=0xABCDABCD, addr=0x200, wreg_o=0.
- LW at 0x101 → exc_adel=1, bad_vaddr=0x101, no dbus_req, stallreq=0; SW at 0x102 → exc_ades=1.
- rst low while in REQ → dbus_req falls asynchronously; after release, FSM is in IDLE and a late ack is ignored.
- DONE with stall_hold=1 for 2 cycles → stays in DONE, a single bus access total, wdata_o stable; ADDU op (aluop 0x21) → passthrough, stallreq=0.
